bec_ladder_sequencer: RTL and testbench

BEC_LADDER_SEQUENCER -- requirements
Module: bec_ladder_sequencer

---
 rtl/bec_pkg.sv | 41 ++++
 rtl/bec_watchdog.sv | 36 +++
 rtl/bec_ladder_sequencer.sv | 109 ++++++++++
 tb/tb_bec_ladder_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bec_pkg.sv
// Shared definitions for the BEC ladder controller and core: state encoding,
// default widths and the state-to-output decode.
package bec_pkg;

  localparam int BEC_KEY_W = 163;
  localparam int BEC_TMO_W = 10;
  localparam int BEC_IDX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } bec_state_e;

  typedef struct packed {
    logic step_req;
    logic busy;
    logic done;
    logic err;
  } bec_flags_t;

  // Outputs are a pure decode of the state register, so no input reaches them.
  function automatic bec_flags_t bec_decode(input bec_state_e s);
    bec_flags_t f;
    f = '0;
    case (s)
      ST_ISSUE: begin
        f.step_req = 1'b1;
        f.busy     = 1'b1;
      end
      ST_WAIT: f.busy = 1'b1;
      ST_DONE: f.done = 1'b1;
      ST_ERR:  f.err  = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bec_watchdog.sv
// Saturating wait-cycle counter; expired flags the cycle in which an enabled
// increment would take the count to all-ones.
module bec_watchdog
  import bec_pkg::*;
#(
  parameter int TMO_W = BEC_TMO_W
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] CNT_LAST = CNT_MAX - TMO_W'(1);

  logic [TMO_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // Look-ahead compare lets the controller leave WAIT on the same edge the
  // count reaches all-ones, i.e. after exactly 2^TMO_W-1 idle wait cycles.
  assign expired = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/bec_ladder_sequencer.sv
// Montgomery-ladder step sequencer: walks the scalar MSB-first, issuing one
// step request per key bit to the BEC core and guarding each wait with a watchdog.
module bec_ladder_sequencer
  import bec_pkg::*;
#(
  parameter int KEY_W = BEC_KEY_W,
  parameter int TMO_W = BEC_TMO_W
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 start,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 abort,
  input  logic                 step_ack,
  output logic                 step_req,
  output logic                 ki,
  output logic [BEC_IDX_W-1:0] iter_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [BEC_IDX_W-1:0] ITER_TOP = BEC_IDX_W'(KEY_W - 1);

  bec_state_e           state, state_next;
  logic [KEY_W-1:0]     key_reg, key_next;
  logic [BEC_IDX_W-1:0] iter_q, iter_next;
  logic                 wd_clear, wd_en, wd_expired;
  bec_flags_t           flags;

  bec_watchdog #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .clear    (wd_clear),
    .enable   (wd_en),
    .expired  (wd_expired)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    state_next = state;
    key_next   = key_reg;
    iter_next  = iter_q;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
      key_next   = '0;
      iter_next  = '0;
      wd_clear   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_next   = key_in;
            iter_next  = ITER_TOP;
            wd_clear   = 1'b1;
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: state_next = ST_WAIT;
        ST_WAIT: begin
          // An ack in the expiry cycle wins: the timeout branch is only taken without one.
          if (step_ack) begin
            key_next = key_reg << 1;
            wd_clear = 1'b1;
            if (iter_q != '0) begin
              iter_next  = iter_q - BEC_IDX_W'(1);
              state_next = ST_ISSUE;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            wd_en = 1'b1;
            if (wd_expired) state_next = ST_ERR;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        ST_ERR:  state_next = ST_ERR;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state   <= ST_IDLE;
      key_reg <= '0;
      iter_q  <= '0;
    end else begin
      state   <= state_next;
      key_reg <= key_next;
      iter_q  <= iter_next;
    end
  end

  assign flags    = bec_decode(state);
  assign step_req = flags.step_req;
  assign busy     = flags.busy;
  assign done     = flags.done;
  assign err      = flags.err;
  assign ki       = key_reg[KEY_W-1];
  assign iter_idx = iter_q;

endmodule

// File: tb/tb_bec_ladder_sequencer.sv
// Self-checking bench for bec_ladder_sequencer: table-driven full ladders with a
// ki/iter_idx scoreboard, plus timeout, abort and reset corner sequences.
module tb_bec_ladder_sequencer;
  localparam int KW = 163;

  typedef struct {
    logic [KW-1:0] key;
    int            lat;
    int            exp_done;
  } vec_t;

  typedef struct {
    logic       ki;
    logic [7:0] idx;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] key_in;
  logic          abort;
  logic          step_ack;
  logic          step_req;
  logic          ki;
  logic [7:0]    iter_idx;
  logic          busy;
  logic          done;
  logic          err;

  logic ack_auto = 1'b0;
  logic ack_man  = 1'b0;
  int   ack_lat  = 2;
  int   ack_limit = 0;
  int   ack_count = 0;
  int   ack_cd    = 0;
  int   steps_seen = 0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  sb_t  exp_q[$];
  vec_t vecs[5];

  assign step_ack = ack_auto | ack_man;

  bec_ladder_sequencer #(
    .KEY_W(KW),
    .TMO_W(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .start    (start),
    .key_in   (key_in),
    .abort    (abort),
    .step_ack (step_ack),
    .step_req (step_req),
    .ki       (ki),
    .iter_idx (iter_idx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_key(input logic [KW-1:0] k);
    for (int i = KW - 1; i >= 0; i--) begin
      sb_t e;
      e.ki  = k[i];
      e.idx = 8'(i);
      exp_q.push_back(e);
    end
  endtask

  // Core model: acks in the (lat+1)-th cycle after a request, i.e. after lat
  // full WAIT cycles, for as many requests as ack_limit allows.
  always @(negedge clk) begin
    ack_auto = 1'b0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) ack_auto = 1'b1;
    end
    if (step_req === 1'b1 && ack_count < ack_limit) begin
      ack_count++;
      ack_cd = ack_lat + 1;
    end
  end

  // Scoreboard: every step request must match the next expected key bit and index.
  always @(negedge clk) begin
    sb_t e;
    if (step_req === 1'b1) begin
      steps_seen++;
      if (exp_q.size() == 0) begin
        check("step_req_unexpected", step_req, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("ki", ki, e.ki);
        check("iter_idx", iter_idx, e.idx);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_step_req"}, step_req, 1'b0);
    check({tag, "_ki"}, ki, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_iter_idx"}, iter_idx, 8'd0);
  endtask

  task automatic wait_reqs(input int n, output int got);
    got = 0;
    for (int g = 0; g < 2000 && got < n; g++) begin
      if (step_req === 1'b1) got++;
      if (got < n) @(negedge clk);
    end
  endtask

  task automatic run_ladder(input int v);
    int t0;
    int s0;
    ack_lat   = vecs[v].lat;
    ack_limit = ack_count + 1000;
    s0        = steps_seen;
    key_in    = vecs[v].key;
    start     = 1'b1;
    push_key(vecs[v].key);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("first_req", step_req, 1'b1);
    check("first_idx", iter_idx, 8'd162);
    check("busy_run", busy, 1'b1);
    while (done !== 1'b1 && (cyc - t0) < 4000) @(negedge clk);
    check("done_cycle", cyc - t0, vecs[v].exp_done);
    check("step_count", steps_seen - s0, KW);
    check("sb_drained", exp_q.size(), 0);
    check("end_idx", iter_idx, 8'd0);
    check("no_err", err, 1'b0);
    @(negedge clk);
    check("done_width", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout: bench still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int  k;
    int  guard;
    bit  ok;

    vecs[0] = '{key: 163'h1, lat: 2, exp_done: 653};
    vecs[1] = '{key: (163'h5 << 160) | 163'h3, lat: 2, exp_done: 653};
    vecs[2] = '{key: {3'b010, 160'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE_1234_5678},
                lat: 0, exp_done: 327};
    vecs[3] = '{key: '1, lat: 5, exp_done: 1142};
    vecs[4] = '{key: {3'b101, 160'h5555_AAAA_3333_CCCC_0000_FFFF_1357_9BDF_2468_ACE0},
                lat: 14, exp_done: 2609};

    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    key_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // An ack outside WAIT changes nothing.
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    check("idle_ack_busy", busy, 1'b0);
    check("idle_ack_idx", iter_idx, 8'd0);
    @(negedge clk);

    // Full ladders; lat=14 puts every ack on the last watchdog cycle.
    for (int v = 0; v < 5; v++) run_ladder(v);

    // Ack withheld after the third request: timeout after 15 WAIT cycles.
    ack_lat   = 2;
    ack_limit = ack_count + 2;
    key_in    = vecs[4].key;
    start     = 1'b1;
    push_key(vecs[4].key);
    @(negedge clk);
    start = 1'b0;
    wait_reqs(3, k);
    check("stall_third_req", k, 3);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (err !== 1'b0 || busy !== 1'b1 || step_req !== 1'b0) ok = 1'b0;
    end
    check("stall_window", ok, 1'b1);
    @(negedge clk);
    check("tmo_err", err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_step_req", step_req, 1'b0);
    start  = 1'b1;
    key_in = vecs[0].key;
    @(negedge clk);
    start = 1'b0;
    check("err_sticky", err, 1'b1);
    check("err_start_ignored", step_req, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_err", err, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_idx", iter_idx, 8'd0);
    check("abort_ki", ki, 1'b0);
    exp_q.delete();

    // Abort and ack in the same WAIT cycle at iter_idx 100.
    ack_lat   = 2;
    ack_limit = ack_count + 62;
    key_in    = vecs[2].key;
    start     = 1'b1;
    push_key(vecs[2].key);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(step_req === 1'b1 && iter_idx == 8'd100) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_idx100", iter_idx, 8'd100);
    @(negedge clk);
    ack_man = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    abort   = 1'b0;
    check("race_busy", busy, 1'b0);
    check("race_done", done, 1'b0);
    check("race_idx", iter_idx, 8'd0);
    check("race_err", err, 1'b0);
    exp_q.delete();
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("race_quiet", ok, 1'b1);
    run_ladder(0);

    // Start pulses while busy must not re-latch; then a one-cycle reset mid-ladder.
    ack_lat   = 2;
    ack_limit = ack_count + 1000;
    key_in    = vecs[3].key;
    start     = 1'b1;
    push_key(vecs[3].key);
    @(negedge clk);
    start = 1'b0;
    wait_reqs(10, k);
    check("busy_ten_reqs", k, 10);
    @(negedge clk);
    start  = 1'b1;
    key_in = ~vecs[3].key;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_reqs(2, k);
    check("busy_more_reqs", k, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midrst");
    exp_q.delete();
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("midrst_quiet", ok, 1'b1);
    run_ladder(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
